// File: rtl/sel_mux_scan.sv
// Channel selector with registered output: manual select loads or an automatic
// round-robin scan that dwells DWELL cycles on each channel.
module sel_mux_scan #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2,
    parameter int DWELL    = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] in_bus,
    input  logic [SEL_W-1:0]          sel,
    input  logic                      sel_we,
    input  logic                      mode,
    input  logic                      hold,
    output logic [WIDTH-1:0]          y,
    output logic [SEL_W-1:0]          y_ch,
    output logic                      y_chg,
    output logic                      sel_err
);

    localparam logic [SEL_W:0]   CH_LIM  = (SEL_W+1)'(CHANNELS);
    localparam logic [SEL_W-1:0] CH_LAST = SEL_W'(CHANNELS - 1);
    localparam logic [15:0]      DW_LAST = 16'(DWELL - 1);

    logic [SEL_W-1:0] cur_ch_q, cur_ch_d;
    logic [15:0]      dcnt_q, dcnt_d;
    logic [WIDTH-1:0] y_q;
    logic [SEL_W-1:0] y_ch_q;
    logic             y_chg_q;
    logic             sel_err_q;
    logic             sel_ok;
    logic [WIDTH-1:0] ch_data [CHANNELS];

    for (genvar k = 0; k < CHANNELS; k++) begin : g_unpack
        assign ch_data[k] = in_bus[k*WIDTH +: WIDTH];
    end

    assign sel_ok = ({1'b0, sel} < CH_LIM);

    // Select load outranks everything; a rejected load also suppresses the scan step.
    always_comb begin
        cur_ch_d = cur_ch_q;
        dcnt_d   = dcnt_q;
        if (sel_we) begin
            if (sel_ok) begin
                cur_ch_d = sel;
                dcnt_d   = '0;
            end
        end else if (!mode) begin
            dcnt_d = '0;
        end else if (!hold) begin
            if (dcnt_q == DW_LAST) begin
                dcnt_d   = '0;
                cur_ch_d = (cur_ch_q == CH_LAST) ? '0 : cur_ch_q + 1'b1;
            end else begin
                dcnt_d = dcnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_ch_q  <= '0;
            dcnt_q    <= '0;
            y_q       <= '0;
            y_ch_q    <= '0;
            y_chg_q   <= 1'b0;
            sel_err_q <= 1'b0;
        end else begin
            cur_ch_q  <= cur_ch_d;
            dcnt_q    <= dcnt_d;
            y_q       <= ch_data[cur_ch_q];
            y_ch_q    <= cur_ch_q;
            y_chg_q   <= (cur_ch_q != y_ch_q);
            sel_err_q <= sel_we & ~sel_ok;
        end
    end

    assign y       = y_q;
    assign y_ch    = y_ch_q;
    assign y_chg   = y_chg_q;
    assign sel_err = sel_err_q;

endmodule

// File: doc/sel_mux_scan.md
SEL_MUX_SCAN -- requirements
Module: sel_mux_scan

Interface
REQ-001 SHALL have parameter WIDTH, default 4: bit width of each data channel.
REQ-002 SHALL have parameter CHANNELS, default 4: number of input channels, legal range 2..16.
REQ-003 SHALL have parameter SEL_W, default 2: select width, SHALL equal clog2(CHANNELS).
REQ-004 SHALL have parameter DWELL, default 8: cycles spent on each channel in scan mode, legal range 1..65535.
REQ-005 SHALL have port clk, input, 1: single clock, all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-007 SHALL have port in_bus, input, CHANNELS*WIDTH: channel k occupies bits [k*WIDTH +: WIDTH].
REQ-008 SHALL have port sel, input, SEL_W: requested channel, sampled only when sel_we=1.
REQ-009 SHALL have port sel_we, input, 1: select-load strobe.
REQ-010 SHALL have port mode, input, 1: 0 = manual, 1 = auto-scan.
REQ-011 SHALL have port hold, input, 1: freezes the scan sequencer while high.
REQ-012 SHALL have port y, output, WIDTH: registered selected data.
REQ-013 SHALL have port y_ch, output, SEL_W: channel index that y currently reflects.
REQ-014 SHALL have port y_chg, output, 1: one-cycle pulse when y_ch takes a new value.
REQ-015 SHALL have port sel_err, output, 1: one-cycle pulse on a rejected select load.

Function
REQ-016 SHALL hold an internal channel register cur_ch (SEL_W bits) and a dwell counter dcnt (16 bits).
REQ-017 SHALL register y <= in_bus[cur_ch] and y_ch <= cur_ch every cycle, with no bypass.
- Latency: in_bus to y is 1 cycle. sel_we to y/y_ch is 2 cycles: cur_ch updates at t+1, y at t+2.
REQ-018 SHALL drive y_chg high for one cycle whenever the registered y_ch differs from its previous value.
REQ-019 SHALL, on sel_we=1 with sel < CHANNELS, load cur_ch <= sel and clear dcnt <= 0, in either mode.
REQ-020 SHALL, on sel_we=1 with sel >= CHANNELS, leave cur_ch and dcnt unchanged and pulse sel_err the next cycle.
REQ-021 SHALL, in manual mode (mode=0), change cur_ch only via sel_we, and hold dcnt at 0.
REQ-022 SHALL, in scan mode (mode=1, hold=0, sel_we=0), increment dcnt each cycle.
- When dcnt = DWELL-1: clear dcnt to 0 and advance cur_ch to (cur_ch+1), wrapping CHANNELS-1 -> 0.
REQ-023 SHALL, in scan mode with hold=1, freeze both cur_ch and dcnt. y continues to track in_bus[cur_ch].
REQ-024 SHALL give sel_we priority over a coincident scan advance; hold does not block sel_we.
REQ-025 SHALL, on a mode 0->1 transition, start scanning from the current cur_ch with dcnt = 0.
REQ-026 SHALL, on a mode 1->0 transition, keep cur_ch and clear dcnt to 0.
REQ-027 SHALL, with DWELL=1, advance cur_ch every cycle in unheld scan mode.
REQ-028 SHALL never produce a cur_ch value >= CHANNELS.

Reset
REQ-029 SHALL, while rst=1 at a clock edge, set cur_ch=0, dcnt=0, y=0, y_ch=0, y_chg=0 and sel_err=0.
REQ-030 SHALL give rst priority over sel_we, mode and hold, including when asserted mid-scan.
REQ-031 SHALL, in the first cycle after rst deasserts, have y reflect in_bus[0] and keep y_chg=0.

Verification (WIDTH=4, CHANNELS=4, DWELL=3 unless stated)
REQ-032 Reset: in_bus=16'hDCBA, rst pulse -> y=0 during reset, then y=4'hA, y_ch=0, y_chg=0.
REQ-033 Manual load: mode=0, sel_we pulse with sel=2 at t -> y=4'hC and y_ch=2 at t+2, y_chg=1 for that single cycle.
REQ-034 Scan wrap: mode=1 from ch 3 -> y_ch sequence 3,3,3,0,0,0,1..., with one y_chg pulse per change.
REQ-035 Hold and priority:
- hold=1 for 5 cycles mid-dwell -> y_ch and dcnt frozen, resuming with the remaining dwell.
- sel_we with sel=1 on the wrap cycle -> cur_ch=1, not the incremented value.
REQ-036 Bad select: CHANNELS=3, sel=3 with sel_we -> sel_err pulses once, y_ch unchanged, no y_chg.
REQ-037 Reset mid-scan: rst during dcnt=1 on ch 2 -> y_ch=0 after reset, scan restarts with a full dwell on ch 0.
